// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential restoring integer square root, one root bit per clock
module sqrt_seq #(
  parameter int WIDTH = 16,
  parameter int ROUND = 0
) (
  input  logic               clk,
  input  logic               CLR,
  input  logic               Start,
  input  logic [WIDTH-1:0]   In1,
  output logic [WIDTH/2-1:0] Out,
  output logic [WIDTH/2:0]   Rem,
  output logic               Done,
  output logic               Busy,
  output logic [1:0]         state
);
  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10, BAD = 2'b11} st_t;
  st_t st, nx;
  logic [WIDTH-1:0] rad;
  logic [N-1:0]     root;
  logic [N+1:0]     remr;
  logic [CW-1:0]    cnt;
  logic [N+1:0]     rsh, trial, rdif;
  logic             ge, last;
  logic [N-1:0]     froot, rroot;
  logic [N:0]       frem;
  // one restoring step: bring down two radicand bits, try subtracting (root<<2)|1
  always_comb begin
    rsh   = (remr << 2) | {{N{1'b0}}, rad[WIDTH-1 -: 2]};
    trial = {root, 2'b01};
    ge    = rsh >= trial;
    rdif  = ge ? rsh - trial : rsh;
    froot = {root[N-2:0], ge};
    frem  = (N+1)'(rdif);
    rroot = (ROUND != 0 && frem > {1'b0, froot} && !(&froot)) ? froot + 1'b1 : froot;
    last  = cnt == CW'(N - 1);
  end
  // next state: the unused encoding falls back to IDLE
  always_comb begin
    nx = st == IDLE ? (Start ? CALC : IDLE) : st == CALC ? (last ? DONE : CALC) : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) st <= IDLE;
    else     st <= nx;
  end
  // datapath: capture on accept, iterate in CALC, publish on the final step
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      rad  <= '0;
      root <= '0;
      remr <= '0;
      cnt  <= '0;
      Out  <= '0;
      Rem  <= '0;
    end else if (st == IDLE && Start) begin
      rad  <= In1;
      root <= '0;
      remr <= '0;
      cnt  <= '0;
    end else if (st == CALC) begin
      rad  <= rad << 2;
      root <= froot;
      remr <= rdif;
      cnt  <= cnt + CW'(1);
      if (last) begin
        Out <= rroot;
        Rem <= frem;
      end
    end
  end
  assign Busy  = st == CALC;
  assign Done  = st == DONE;
  assign state = st;
endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq: scoreboard bench for floor/rounded 16-bit and exhaustive 8-bit roots
module tb_sqrt_seq;
  logic clk, clr, start, start8;
  logic [15:0] in16;
  logic [7:0]  in8;
  logic [7:0]  out0, out1;
  logic [8:0]  rem0, rem1;
  logic [3:0]  out2;
  logic [4:0]  rem2;
  logic done0, busy0, done1, busy1, done2, busy2;
  logic [1:0] st0, st1, st2;
  int total = 0, bad = 0;
  int eo0[$], er0[$], eo1[$], er1[$], eo2[$], er2[$];
  int sv[11];

  sqrt_seq #(.WIDTH(16), .ROUND(0)) d0 (.clk(clk), .CLR(clr), .Start(start), .In1(in16),
    .Out(out0), .Rem(rem0), .Done(done0), .Busy(busy0), .state(st0));
  sqrt_seq #(.WIDTH(16), .ROUND(1)) d1 (.clk(clk), .CLR(clr), .Start(start), .In1(in16),
    .Out(out1), .Rem(rem1), .Done(done1), .Busy(busy1), .state(st1));
  sqrt_seq #(.WIDTH(8), .ROUND(0)) d2 (.clk(clk), .CLR(clr), .Start(start8), .In1(in8),
    .Out(out2), .Rem(rem2), .Done(done2), .Busy(busy2), .state(st2));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void check(string n, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  function automatic int isqrt(int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // monitors: pop the oldest expectation whenever a DUT reports Done
  always @(negedge clk) if (done0) begin
    if (eo0.size() == 0) check("d0 unexpected done", 1, 0);
    else begin check("d0 out", int'(out0), eo0.pop_front()); check("d0 rem", int'(rem0), er0.pop_front()); end
  end
  always @(negedge clk) if (done1) begin
    if (eo1.size() == 0) check("d1 unexpected done", 1, 0);
    else begin check("d1 out", int'(out1), eo1.pop_front()); check("d1 rem", int'(rem1), er1.pop_front()); end
  end
  always @(negedge clk) if (done2) begin
    if (eo2.size() == 0) check("d2 unexpected done", 1, 0);
    else begin check("d2 out", int'(out2), eo2.pop_front()); check("d2 rem", int'(rem2), er2.pop_front()); end
  end

  task automatic issue16(input int v, input int fo, input int fr, input int ro);
    int lat;
    @(negedge clk);
    in16 = 16'(v);
    start = 1;
    eo0.push_back(fo); er0.push_back(fr); eo1.push_back(ro); er1.push_back(fr);
    @(negedge clk);
    start = 0;
    in16 = ~in16;
    check("busy16", int'(busy0), 1);
    lat = 0;
    while (!done0 && lat < 30) begin @(negedge clk); lat++; end
    check("latency16", lat, 8);
    check("d1 done aligned", int'(done1), 1);
    @(negedge clk);
    check("done16 width", int'(done0), 0);
    check("idle after done16", int'(st0), 0);
  endtask

  task automatic issue8(input int v);
    int lat, r;
    r = isqrt(v);
    @(negedge clk);
    in8 = 8'(v);
    start8 = 1;
    eo2.push_back(r); er2.push_back(v - r * r);
    @(negedge clk);
    start8 = 0;
    in8 = ~in8;
    lat = 0;
    while (!done2 && lat < 30) begin @(negedge clk); lat++; end
    check("latency8", lat, 4);
    @(negedge clk);
    check("idle after done8", int'(st2), 0);
  endtask

  int tv[9] = '{0, 144, 150, 160, 65535, 3, 1000, 65280, 65281};
  int to[9] = '{0, 12,  12,  12,  255,   1, 31,   255,   255};
  int tr[9] = '{0, 0,   6,   16,  510,   2, 39,   255,   256};
  int tq[9] = '{0, 12,  12,  13,  255,   2, 32,   255,   255};

  initial begin
    int lat;
    clr = 1; start = 0; start8 = 0; in16 = 0; in8 = 0;
    #3;
    check("rst state", int'(st0), 0);
    check("rst out", int'(out0), 0);
    check("rst rem", int'(rem0), 0);
    check("rst done", int'(done0), 0);
    check("rst busy", int'(busy0), 0);
    check("rst out8", int'(out2), 0);
    start = 1;
    repeat (2) @(negedge clk);
    check("start ignored in reset", int'(st0), 0);
    start = 0;
    clr = 0;
    for (int i = 0; i < 9; i++) issue16(tv[i], to[i], tr[i], tq[i]);
    repeat (3) @(negedge clk);
    check("hold out", int'(out0), 255);
    check("hold rem", int'(rem0), 256);
    // Start held high: second accept happens one IDLE cycle after DONE
    @(negedge clk);
    in16 = 150; start = 1;
    eo0.push_back(12); er0.push_back(6); eo1.push_back(12); er1.push_back(6);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      sv[i] = int'(st0);
      if (i == 9) begin
        in16 = 160;
        eo0.push_back(12); er0.push_back(16); eo1.push_back(13); er1.push_back(16);
      end
      if (i == 10) start = 0;
    end
    for (int i = 0; i < 8; i++) check("held calc", sv[i], 1);
    check("held done", sv[8], 2);
    check("held idle", sv[9], 0);
    check("held recalc", sv[10], 1);
    lat = 0;
    while (!done0 && lat < 30) begin @(negedge clk); lat++; end
    check("held second done", int'(done0), 1);
    @(negedge clk);
    // abort with CLR in the 4th CALC cycle
    @(negedge clk);
    in16 = 1000; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check("abort pre busy", int'(busy0), 1);
    clr = 1;
    #1;
    check("abort state", int'(st0), 0);
    check("abort out", int'(out0), 0);
    check("abort rem", int'(rem0), 0);
    check("abort busy", int'(busy0), 0);
    check("abort out1", int'(out1), 0);
    @(negedge clk);
    clr = 0;
    repeat (12) @(negedge clk);
    issue16(81, 9, 0, 9);
    issue8(255);
    for (int v = 0; v < 256; v++) issue8(v);
    repeat (2) @(negedge clk);
    check("q0 drained", eo0.size(), 0);
    check("q1 drained", eo1.size(), 0);
    check("q2 drained", eo2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sqrt_seq.md
SQRT_SEQ -- requirements
Module: sqrt_seq

Interface
REQ-001 Parameter WIDTH, default 16, radicand width in bits; SHALL be even and >= 4.
REQ-002 Parameter ROUND, default 0; 0 = floor root, 1 = round-to-nearest root.
REQ-003 Local constant N = WIDTH/2, the root width and the iteration count.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 CLR  input  1  reset, asynchronous and active-high.
REQ-006 Start  input  1  request; sampled only in IDLE.
REQ-007 In1  input  WIDTH  unsigned radicand; captured on the accepting edge.
REQ-008 Out  output  N  root result.
REQ-009 Rem  output  N+1  floor remainder, In1 - floor_root^2.
REQ-010 Done  output  1  result-valid pulse.
REQ-011 Busy  output  1  high while in CALC.
REQ-012 state  output  2  present FSM state: IDLE=00, CALC=01, DONE=10.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE; encoding 11 SHALL return to IDLE on the next edge with outputs unchanged.
REQ-014 In IDLE with Start=1 at an edge: capture In1, clear the partial root, partial remainder and iteration counter, and go to CALC.
REQ-015 In IDLE with Start=0: hold state and hold Out/Rem at their previous values.
REQ-016 CALC: each edge SHALL resolve one root bit, MSB first, by the restoring digit-by-digit method.
REQ-016a Per iteration: shift the next 2 radicand bits into the remainder; trial = (root<<2)|1.
REQ-016b If remainder >= trial: remainder -= trial and the root bit = 1; otherwise the root bit = 0.
REQ-017 The internal remainder SHALL be N+2 bits wide so that no intermediate overflow occurs.
REQ-018 On the Nth CALC edge: load Out and Rem with the final values and go to DONE.
REQ-019 Latency: if Start is accepted at edge E0, Done SHALL be high for exactly the cycle after edge E(N), i.e. E8 for WIDTH=16.
REQ-020 DONE SHALL last exactly one cycle and return to IDLE unconditionally; Start in DONE SHALL be ignored.
REQ-021 Start in CALC SHALL be ignored; In1 changes after capture SHALL NOT affect the result.
REQ-022 Out and Rem SHALL hold their values from DONE until the next accepting edge.
REQ-023 Out and Rem SHALL NOT be guaranteed valid during CALC.
REQ-024 ROUND=1: if the floor remainder > the floor root, Out = floor_root + 1; ties cannot occur for integer inputs.
REQ-025 ROUND=1: a rounded value of 2^N SHALL saturate to 2^N - 1.
REQ-026 Rem SHALL always report the floor remainder, in both modes.
REQ-027 Busy SHALL be 1 exactly when state = CALC; Done SHALL be 1 exactly when state = DONE.

Reset
REQ-028 CLR=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, Out=0, Rem=0, Done=0, Busy=0, and clear the counter and internal registers.
REQ-029 CLR asserted in CALC or DONE SHALL abort the operation with no Done pulse.
REQ-030 While CLR=1, Start SHALL be ignored.
REQ-031 After CLR deasserts, the first Start SHALL be accepted normally.

Verification (WIDTH=16 unless noted)
REQ-032 In1=0, Start pulse -> after 8 CALC edges Done=1 for 1 cycle, Out=0, Rem=0.
REQ-033 ROUND=0: 144 -> Out=12, Rem=0; 150 -> Out=12, Rem=6; 65535 -> Out=255, Rem=510.
REQ-034 ROUND=1: 150 -> Out=12; 160 -> Out=13, Rem=16; 65535 -> Out=255 (saturated), Rem=510.
REQ-035 Start=1 held continuously from In1=150 -> Busy for 8 cycles, Done 1 cycle, 1 IDLE cycle, then a new CALC; the second result is correct for the In1 value at re-acceptance.
REQ-036 CLR pulse in the 4th CALC cycle -> state=00 and Out=0 asynchronously, no Done; next Start with In1=81 -> Out=9, Rem=0.
REQ-037 WIDTH=8, In1=255 -> Done after edge E4, Out=15, Rem=30; exhaustive check of all 256 inputs against a floor-sqrt model.
